// File: rtl/clk_en_sched_pkg.sv
// Shared encodings and defaults for the run/step/hold tick scheduler.
package clk_en_sched_pkg;

  localparam int unsigned CntWDefault = 26;
  localparam int unsigned DivDefault  = 50000000;

  // Encoding is visible on the State debug/LED output, so values are fixed.
  typedef enum logic [1:0] {
    StHold   = 2'd0,
    StRun    = 2'd1,
    StStep   = 2'd2,
    StReload = 2'd3
  } state_e;

endpackage

// File: rtl/clk_en_sched_tick_counter.sv
// Divide counter: counts up to limit_i, flags terminal count and wraps to zero.
module clk_en_sched_tick_counter
  import clk_en_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o  = (cnt_q == limit_i);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// Run/step/hold controller producing a tick enable and a toggling slow clock,
// with divisor reloads that only commit on a tick boundary or from hold.
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned DIV_DEFAULT = DivDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             step_req_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_in_i,
  output logic             div_ack_o,
  output logic             busy_o,
  output logic             tick_en_o,
  output logic             clk_out_o,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DivMin = CNT_W'(1);

  state_e           state_q, state_d;
  logic             step_q;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_en_q, clk_out_q, div_ack_q;

  logic             step_edge;
  logic             fire, commit;
  logic             cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0] cnt;

  assign step_edge = step_req_i & ~step_q;

  clk_en_sched_tick_counter #(
    .CNT_W(CNT_W)
  ) u_tick_counter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(cnt_clr),
    .en_i   (cnt_en),
    .limit_i(div_q),
    .tc_o   (tc),
    .cnt_o  (cnt)
  );

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    commit  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StHold: begin
        cnt_clr = 1'b1;
        if (busy_q) begin
          state_d = StReload;
        end else if (run_i) begin
          state_d = StRun;
        end else if (step_edge) begin
          state_d = StStep;
        end
      end
      StReload: begin
        commit  = 1'b1;
        cnt_clr = 1'b1;
        state_d = StHold;
      end
      StRun: begin
        cnt_en = 1'b1;
        if (tc) begin
          fire   = 1'b1;
          commit = busy_q;
        end
        // A terminal count on the same cycle as Run dropping still ticks.
        if (!run_i) begin
          cnt_clr = 1'b1;
          state_d = StHold;
        end
      end
      StStep: begin
        fire    = 1'b1;
        state_d = StHold;
      end
      default: state_d = StHold;
    endcase
  end

  // A load on a commit cycle: the old pending value commits, the new one stays pending.
  always_comb begin
    busy_d = busy_q;
    pend_d = pend_q;
    div_d  = div_q;
    if (commit) begin
      div_d  = pend_q;
      busy_d = 1'b0;
    end
    if (div_load_i) begin
      pend_d = (div_in_i == '0) ? DivMin : div_in_i;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StHold;
      step_q    <= 1'b0;
      busy_q    <= 1'b0;
      pend_q    <= DivRst;
      div_q     <= DivRst;
      tick_en_q <= 1'b0;
      clk_out_q <= 1'b0;
      div_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_req_i;
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      div_q     <= div_d;
      tick_en_q <= fire;
      clk_out_q <= clk_out_q ^ fire;
      div_ack_q <= commit;
    end
  end

  assign tick_en_o = tick_en_q;
  assign clk_out_o = clk_out_q;
  assign div_ack_o = div_ack_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;

  cnt_le_div_a: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt <= div_q);

endmodule

// File: tb/tb_clk_en_sched.sv
// Randomised and directed bench for clk_en_sched with a queue-based scoreboard.
module tb_clk_en_sched;

  localparam int CW     = 26;
  localparam int DIVDEF = 9;
  localparam int MHold = 0, MRun = 1, MStep = 2, MReload = 3;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          run_i, step_req_i, div_load_i;
  logic [CW-1:0] div_in_i;
  logic          div_ack_o, busy_o, tick_en_o, clk_out_o;
  logic [1:0]    state_o;

  clk_en_sched #(
    .CNT_W      (CW),
    .DIV_DEFAULT(DIVDEF)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .run_i     (run_i),
    .step_req_i(step_req_i),
    .div_load_i(div_load_i),
    .div_in_i  (div_in_i),
    .div_ack_o (div_ack_o),
    .busy_o    (busy_o),
    .tick_en_o (tick_en_o),
    .clk_out_o (clk_out_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic     busy;
    logic [1:0] st;
    logic     clk_out;
  } stat_t;

  int    tick_q[$];
  int    ack_q[$];
  stat_t stat_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Reference model: mode, cycles left until the next tick, committed and pending divisor.
  int mode, left, mdiv, mpend;
  bit mbusy, mstep_prev, mclk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic model_reset();
    mode = MHold; left = 0; mdiv = DIVDEF; mpend = DIVDEF;
    mbusy = 0; mstep_prev = 0; mclk = 0;
    tick_q.delete(); ack_q.delete(); stat_q.delete();
  endtask

  task automatic model_step();
    bit rise, fire, commit;
    int nxt;
    stat_t s;
    rise = step_req_i && !mstep_prev;
    fire = 0; commit = 0; nxt = mode;
    case (mode)
      MHold: begin
        if (mbusy) nxt = MReload;
        else if (run_i) begin nxt = MRun; left = mdiv; end
        else if (rise) nxt = MStep;
      end
      MReload: begin commit = 1; nxt = MHold; end
      MRun: begin
        if (left == 0) begin fire = 1; commit = mbusy; end
        else left--;
        if (!run_i) nxt = MHold;
      end
      default: begin fire = 1; nxt = MHold; end
    endcase
    if (commit) begin mdiv = mpend; mbusy = 0; end
    if (fire && mode == MRun) left = mdiv;
    if (div_load_i) begin mpend = (div_in_i == 0) ? 1 : int'(div_in_i); mbusy = 1; end
    mstep_prev = step_req_i;
    mclk ^= fire;
    mode = nxt;
    if (fire) tick_q.push_back(cyc + 1);
    if (commit) ack_q.push_back(cyc + 1);
    s.cyc = cyc + 1; s.busy = mbusy; s.st = 2'(mode); s.clk_out = mclk;
    stat_q.push_back(s);
  endtask

  task automatic drive(input bit r, input bit s, input bit l, input int d);
    run_i = r; step_req_i = s; div_load_i = l; div_in_i = CW'(d);
    model_step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit r, input bit s, input int n);
    repeat (n) drive(r, s, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tick"}, tick_en_o, 0);
    check({tag, "_clkout"}, clk_out_o, 0);
    check({tag, "_ack"}, div_ack_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_state"}, state_o, 0);
  endtask

  task automatic reset_cycles(input int n);
    repeat (n) begin
      run_i = 1'($urandom); step_req_i = 1'($urandom);
      div_load_i = 1'($urandom); div_in_i = CW'($urandom_range(0, 20));
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_reset_outputs("in_reset");
    end
    run_i = 0; step_req_i = 0; div_load_i = 0; div_in_i = '0;
  endtask

  // Monitor: pops expectations whenever the DUT presents (or should present) an event.
  always @(posedge clk) begin
    stat_t s;
    bit    exp_t, exp_a;
    #1;
    if (rst_ni) begin
      if (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
        s = stat_q.pop_front();
        check("busy", busy_o, s.busy);
        check("state", state_o, s.st);
        check("clk_out", clk_out_o, s.clk_out);
      end
      exp_t = (tick_q.size() > 0 && tick_q[0] == cyc);
      if (tick_en_o || exp_t) begin
        check("tick_en", tick_en_o, exp_t);
        if (exp_t) void'(tick_q.pop_front());
      end
      exp_a = (ack_q.size() > 0 && ack_q[0] == cyc);
      if (div_ack_o || exp_a) begin
        check("div_ack", div_ack_o, exp_a);
        if (exp_a) void'(ack_q.pop_front());
      end
    end
  end

  initial begin
    bit r;
    // 1: reset with toggling inputs, then release into HOLD
    rst_ni = 0; run_i = 0; step_req_i = 0; div_load_i = 0; div_in_i = '0;
    model_reset();
    @(negedge clk);
    reset_cycles(5);
    rst_ni = 1;
    idle(0, 0, 3);

    // 2: divisor 3, then free-run
    drive(0, 0, 1, 3);
    idle(1, 0, 20);
    idle(0, 0, 3);

    // 3: step held high for 10 cycles gives one tick; a second rise gives another
    idle(0, 1, 10);
    idle(0, 0, 3);
    idle(0, 1, 2);
    idle(0, 0, 4);

    // 4: clamp of a zero divisor loaded mid-count
    idle(1, 0, 2);
    drive(1, 0, 1, 0);
    idle(1, 0, 12);
    idle(0, 0, 2);

    // 5: back-to-back loads in HOLD and in RUN; Run and step rising together
    drive(0, 0, 1, 5);
    drive(0, 0, 1, 7);
    idle(0, 0, 4);
    idle(1, 0, 2);
    drive(1, 0, 1, 5);
    drive(1, 0, 1, 7);
    idle(1, 0, 20);
    idle(0, 0, 3);
    idle(1, 1, 4);
    idle(0, 0, 3);

    // 6: reset mid-RUN with a divisor pending
    idle(1, 0, 3);
    drive(1, 0, 1, 2);
    idle(1, 0, 1);
    rst_ni = 0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    reset_cycles(3);
    rst_ni = 1;
    idle(1, 0, 25);
    idle(0, 0, 2);

    // random traffic
    r = 0;
    repeat (800) begin
      if ($urandom_range(0, 9) == 0) r = ~r;
      drive(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 5)));
    end
    idle(0, 0, 3);

    check("tick_q_drained", tick_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    check("stat_q_drained", stat_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
